// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target, MSB-first, all CPOL/CPHA modes, valid/ready transmit holding register
module spi_slave #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, tx_shift, hold;
  logic rise, fall, cs_fall, sample, shift, wrap, accept, load;
  always_comb begin
    rise = sclk_s[1] & ~sclk_s[2];
    fall = ~sclk_s[1] & sclk_s[2];
    cs_fall = ~cs_s[1] & cs_s[2];
    sample = state == ACTIVE && !cs_s[1] && ((CPOL ^ CPHA) ? fall : rise);
    shift = state == ACTIVE && !cs_s[1] && ((CPOL ^ CPHA) ? rise : fall);
    wrap = bit_cnt == CW'(DATA_WIDTH - 1);
    accept = tx_valid_i & tx_ready_o;
    load = (state == IDLE && cs_fall) || (sample && wrap);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_s <= {3{CPOL}};
      cs_s <= 3'b111;
      mosi_s <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      hold <= '0;
      miso_o <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      tx_underrun_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk_i};
      cs_s <= {cs_s[1:0], cs_i};
      mosi_s <= {mosi_s[0], mosi_i};
      rx_valid_o <= 1'b0;
      tx_underrun_o <= load & tx_ready_o;
      tx_ready_o <= accept ? 1'b0 : (load | tx_ready_o);
      if (accept) hold <= tx_data_i;
      if (load) begin
        tx_shift <= tx_ready_o ? '0 : hold;
        miso_o <= ~tx_ready_o & hold[DATA_WIDTH-1];
      end
      if (state == IDLE) begin
        busy_o <= cs_fall;
        if (cs_fall) state <= ACTIVE;
      end else if (cs_s[1]) begin
        state <= IDLE;
        busy_o <= 1'b0;
        bit_cnt <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        miso_o <= 1'b0;
      end else if (sample) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s[1]};
        bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
        rx_valid_o <= wrap;
        if (wrap) rx_data_o <= {rx_shift[DATA_WIDTH-2:0], mosi_s[1]};
      end else if (shift && bit_cnt != '0) begin
        tx_shift <= tx_shift << 1;
        miso_o <= tx_shift[DATA_WIDTH-2];
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frame-level check of spi_slave in all four modes against a word/queue model
module tb_spi_slave;
  logic clk = 1'b0, rst = 1'b0, mosi = 1'b0;
  logic [3:0] sclk = 4'b1100, cs = 4'b1111, tx_valid = 4'b0000, cs_prev = 4'b1111;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] miso, tx_ready, rx_valid, underrun, busy;
  logic [7:0] rx_data [4];
  int checks = 0, errors = 0, exp_under = 0, under_seen = 0;
  int cs_cnt [4] = '{default: 0};
  logic [7:0] expq [$];
  logic [7:0] rx_exp;
  bit hold_full [4];
  logic [7:0] hold_val [4];
  logic [7:0] mosi_w [16], tx_w [16], got_w [16];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
      .clk_i(clk), .rst_i(rst), .sclk_i(sclk[g]), .cs_i(cs[g]), .mosi_i(mosi),
      .miso_o(miso[g]), .tx_data_i(tx_data), .tx_valid_i(tx_valid[g]), .tx_ready_o(tx_ready[g]),
      .rx_data_o(rx_data[g]), .rx_valid_o(rx_valid[g]), .tx_underrun_o(underrun[g]), .busy_o(busy[g]));
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      cs_cnt[m] = (rst || cs[m] != cs_prev[m]) ? 0 : cs_cnt[m] + 1;
      if (cs_cnt[m] >= 5) begin
        chk("busy", busy[m], !cs[m]);
        if (cs[m]) chk("miso_idle", miso[m], 1'b0);
      end
      if (rx_valid[m]) begin
        if (expq.size() == 0) chk("rx_unexpected", rx_valid[m], 1'b0);
        else begin
          rx_exp = expq.pop_front();
          chk("rx_data", rx_data[m], rx_exp);
        end
      end
      if (underrun[m]) under_seen++;
    end
    cs_prev = cs;
  end
  task automatic half();
    repeat (6) @(negedge clk);
  endtask
  task automatic send_bits(input int m, input logic [7:0] d, input int n, output logic [7:0] got);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (cpha) begin
        sclk[m] = ~cpol;
        mosi = d[7-i];
        half();
        got = {got[6:0], miso[m]};
        sclk[m] = cpol;
        half();
      end else begin
        mosi = d[7-i];
        half();
        got = {got[6:0], miso[m]};
        sclk[m] = ~cpol;
        half();
        sclk[m] = cpol;
      end
    end
  endtask
  task automatic wr(input int m, input logic [7:0] d, input bit need_busy);
    int t = 0;
    while (!(tx_ready[m] && (busy[m] || !need_busy)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL wr_timeout mode %0d: tx_ready %0b expected 1", m, tx_ready[m]);
    end else begin
      tx_data = d;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
    end
  endtask
  task automatic preload(input int m, input logic [7:0] d);
    wr(m, d, 1'b0);
    hold_full[m] = 1'b1;
    hold_val[m] = d;
  endtask
  task automatic frame(input int m, input int n, input int abort_bits, input int nwrite);
    logic [7:0] exp_tx [17];
    int done;
    done = (abort_bits != 0) ? n - 1 : n;
    exp_tx[0] = hold_full[m] ? hold_val[m] : 8'h00;
    if (!hold_full[m]) exp_under++;
    for (int w = 0; w < done; w++) begin
      exp_tx[w+1] = (w < nwrite) ? tx_w[w] : 8'h00;
      if (w >= nwrite) exp_under++;
    end
    hold_full[m] = nwrite > done;
    if (nwrite > done) hold_val[m] = tx_w[done];
    cs[m] = 1'b0;
    half();
    fork
      begin
        for (int w = 0; w < n; w++) begin
          int nb;
          nb = (abort_bits != 0 && w == n - 1) ? abort_bits : 8;
          if (nb == 8) expq.push_back(mosi_w[w]);
          send_bits(m, mosi_w[w], nb, got_w[w]);
          if (nb == 8) chk("miso_word", got_w[w], exp_tx[w]);
        end
        half();
        cs[m] = 1'b1;
      end
      begin
        for (int k = 0; k < nwrite; k++) wr(m, tx_w[k], 1'b1);
      end
    join
    repeat (8) @(negedge clk);
    chk("rx_pending", expq.size(), 0);
    chk("underrun_count", under_seen, exp_under);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int u0, n, ab, done, nwrite, m;
    logic [7:0] g;
    for (int i = 0; i < 4; i++) begin
      hold_full[i] = 1'b0;
      hold_val[i] = 8'h00;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_miso", miso[i], 1'b0);
      chk("rst_ready", tx_ready[i], 1'b1);
      chk("rst_rx_data", rx_data[i], 8'h00);
      chk("rst_rx_valid", rx_valid[i], 1'b0);
      chk("rst_underrun", underrun[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    preload(0, 8'hA5);
    mosi_w[0] = 8'hB2;
    tx_w[0] = 8'($urandom);
    u0 = under_seen;
    frame(0, 1, 0, 1);
    chk("t1_miso_lit", got_w[0], 8'hA5);
    chk("t1_rx_lit", rx_data[0], 8'hB2);
    chk("t1_ready", tx_ready[0], 1'b1);
    chk("t1_no_underrun", under_seen - u0, 0);
    for (int k = 1; k < 4; k++) begin
      preload(k, 8'hCD);
      mosi_w[0] = 8'hAF;
      tx_w[0] = 8'($urandom);
      frame(k, 1, 0, 1);
      chk("t2_miso_lit", got_w[0], 8'hCD);
      chk("t2_rx_lit", rx_data[k], 8'hAF);
    end
    for (int k = 0; k < 4; k += 3) begin
      preload(k, 8'($urandom));
      for (int i = 0; i < 10; i++) begin
        mosi_w[i] = 8'($urandom);
        tx_w[i] = 8'($urandom);
      end
      frame(k, 10, 0, 10);
    end
    u0 = under_seen;
    mosi_w[0] = 8'hB2;
    tx_w[0] = 8'($urandom);
    frame(0, 1, 0, 1);
    chk("t4_miso_lit", got_w[0], 8'h00);
    chk("t4_rx_lit", rx_data[0], 8'hB2);
    chk("t4_underrun_lit", under_seen - u0, 1);
    preload(0, 8'h5A);
    mosi_w[0] = 8'($urandom);
    tx_w[0] = 8'h96;
    frame(0, 1, 5, 1);
    chk("t5_hold_kept", tx_ready[0], 1'b0);
    chk("t5_rx_unchanged", rx_data[0], 8'hB2);
    mosi_w[0] = 8'h3C;
    tx_w[0] = 8'($urandom);
    frame(0, 1, 0, 1);
    chk("t5_miso_lit", got_w[0], 8'h96);
    chk("t5_rx_lit", rx_data[0], 8'h3C);
    preload(1, 8'h77);
    cs[1] = 1'b0;
    half();
    send_bits(1, 8'($urandom), 3, g);
    #3 rst = 1'b1;
    #1;
    chk("t6_miso", miso[1], 1'b0);
    chk("t6_ready", tx_ready[1], 1'b1);
    chk("t6_rx_data", rx_data[1], 8'h00);
    chk("t6_rx_valid", rx_valid[1], 1'b0);
    chk("t6_underrun", underrun[1], 1'b0);
    chk("t6_busy", busy[1], 1'b0);
    @(negedge clk);
    cs[1] = 1'b1;
    sclk[1] = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) hold_full[i] = 1'b0;
    expq.delete();
    repeat (4) @(negedge clk);
    preload(1, 8'h42);
    mosi_w[0] = 8'($urandom);
    tx_w[0] = 8'($urandom);
    frame(1, 1, 0, 1);
    chk("t6_miso_lit", got_w[0], 8'h42);
    chk("t6_rx_after", rx_data[1], mosi_w[0]);
    for (int r = 0; r < 12; r++) begin
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      done = (ab != 0) ? n - 1 : n;
      nwrite = done + int'($urandom_range(0, 2)) - 1;
      if (nwrite < 0) nwrite = 0;
      if (!hold_full[m] && $urandom_range(0, 1) == 1) preload(m, 8'($urandom));
      for (int i = 0; i < n; i++) begin
        mosi_w[i] = 8'($urandom);
        tx_w[i] = 8'($urandom);
      end
      frame(m, n, ab, nwrite);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) that pairs with the existing spi_master on the same serial link.
- Inputs sclk_i, cs_i and mosi_i are asynchronous. They are synchronized and oversampled in the clk_i domain; the block never clocks logic on sclk_i.
- Shifts MSB-first. The received word goes to a valid-pulse output, and the transmit word comes from a valid/ready holding register.
- Supports all four CPOL/CPHA modes and back-to-back words under a single CS assertion.

Parameters:
- DATA_WIDTH, 8, word length in bits (minimum 2).
- CPOL, 0, SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.

Ports:
- clk_i  in  1  system clock; must run at ≥4x the SCLK frequency.
- rst_i  in  1  asynchronous active-high reset.
- sclk_i  in  1  serial clock from the master.
- cs_i  in  1  chip select, active low.
- mosi_i  in  1  serial data from the master.
- miso_o  out  1  serial data to the master.
- tx_data_i  in  DATA_WIDTH  next word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  holding register is empty.
- rx_data_o  out  DATA_WIDTH  last complete received word.
- rx_valid_o  out  1  one-cycle pulse: rx_data_o was updated.
- tx_underrun_o  out  1  one-cycle pulse: a word load found the holding register empty.
- busy_o  out  1  CS is asserted (synchronized).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - miso_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0.
  - Bit counter, shift registers and holding register cleared.
  - Synchronizers preset: sclk_i side to CPOL, cs_i side to 1.
- Synchronization:
  - sclk_i, cs_i and mosi_i each pass through a 2-FF synchronizer.
  - Edges are detected against a third registered copy.
  - Latency from a pin edge to internal detection is 3 clk_i cycles.
  - The master must provide ≥4 clk_i of setup from CS fall to the first SCLK edge, and ≥2 clk_i of MISO hold after each sampling edge.
- Edge decode:
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other one.
  - SCLK edges are ignored while synced CS is high.
- Holding register:
  - A write is accepted when tx_valid_i && tx_ready_o; tx_ready_o drops on the next cycle.
  - Consumed by a load, after which tx_ready_o returns high the next cycle.
  - An accept and a load in the same cycle: the load takes the holding register's old content (empty → underrun), then the new word is stored.
- Load (tx_shift ← holding register, or all zeros plus a tx_underrun_o pulse if empty) happens:
  - on synced CS fall;
  - on the sample edge that completes a word while CS is still low.
- Sample edge:
  - rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi_sync}.
  - bit_cnt increments, wrapping at DATA_WIDTH to 0.
  - On wrap: rx_data_o ← assembled word, and rx_valid_o pulses for 1 cycle in the cycle after the edge is detected.
- Shift edge: if bit_cnt≠0, tx_shift shifts left by 1; if bit_cnt==0, no shift, because the MSB of the new word is already presented.
- MISO: miso_o = tx_shift[DATA_WIDTH-1] while synced CS is low, else 0. It is registered and changes only on load or shift.
- FSM states:
  - IDLE: CS high. bit_cnt=0, busy_o=0.
  - ACTIVE: entered on CS fall with a load; busy_o=1.
  - ACTIVE→IDLE on CS rise.
- CS rise mid-word (bit_cnt≠0):
  - Frame aborted; partial rx bits discarded; no rx_valid_o.
  - bit_cnt=0; miso_o=0.
  - Holding register contents unaffected.
- CS rise and a sample edge in the same cycle: CS rise wins and the sample is dropped.
- Reset asserted mid-frame: immediate return to reset values; the next frame starts only after a fresh CS fall.

Test Plan:
- Mode 0, holding=0xA5 before CS fall, master sends 0xB2 → miso_o carries bits 1,0,1,0,0,1,0,1. One rx_valid_o with rx_data_o=0xB2, then tx_ready_o=1, tx_underrun_o never pulses.
- Modes 1, 2 and 3 each: tx 0xCD, master sends 0xAF → master receives 0xCD; rx_data_o=0xAF; exactly one rx_valid_o per word.
- Back-to-back, CS held low for 10 words, new tx word written after each tx_ready_o → 10 rx_valid_o pulses with matching random data; MISO MSB of each word is valid before that word's first sample edge.
- Holding register empty at CS fall → tx_underrun_o pulses once, master receives 0x00, received word still 0xB2.
- CS deasserted after 5 bits, then a full 0x3C frame → no rx_valid_o for the aborted frame; next rx_data_o=0x3C; holding register unchanged by the abort.
- rst_i pulsed mid-word → all outputs at reset values within the same cycle; the next full frame completes correctly.
